// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM states
//   ifid_entry_t  : payload held by the skid buffer and the IF/ID register
//   word_align()  : clears the byte-offset bits of an address
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC    = XLEN'(4);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pcplus4;
        logic            valid;
    } ifid_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register.
//   Clk, Rst        : clock, async active-high reset to the bubble
//   flush           : load the bubble (highest priority)
//   hold            : keep current contents (decode stall)
//   load, entry_in  : capture a new entry; with neither hold nor load, a bubble is loaded
//   Instruction, PCPlus4, InstrValid : registered IF/ID contents
module if_id_register
    import fetch_pkg::*;
(
    input  logic            Clk,
    input  logic            Rst,
    input  logic            load,
    input  logic            hold,
    input  logic            flush,
    input  ifid_entry_t     entry_in,
    output logic [XLEN-1:0] Instruction,
    output logic [XLEN-1:0] PCPlus4,
    output logic            InstrValid
);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Instruction <= NOP_INSTR;
            PCPlus4     <= '0;
            InstrValid  <= 1'b0;
        end else if (flush) begin
            Instruction <= NOP_INSTR;
            PCPlus4     <= '0;
            InstrValid  <= 1'b0;
        end else if (!hold) begin
            if (load) begin
                Instruction <= entry_in.instr;
                PCPlus4     <= entry_in.pcplus4;
                InstrValid  <= entry_in.valid;
            end else begin
                Instruction <= NOP_INSTR;
                PCPlus4     <= '0;
                InstrValid  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem request, one-entry
// skid buffer for decode stalls, redirect handling, and the IF/ID register.
//   Clk, Rst                      : clock, async active-high reset
//   ImemReq, ImemAddr             : registered request and word address
//   ImemAck, ImemRdata            : one-cycle ack with read data
//   Stall                         : decode cannot accept, hold IF/ID
//   RedirectValid, RedirectPC     : taken branch/jump target
//   Instruction, PCPlus4, InstrValid : IF/ID contents to decode
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        Clk,
    input  logic        Rst,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemRdata,
    input  logic        Stall,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectPC,
    output logic [31:0] Instruction,
    output logic [31:0] PCPlus4,
    output logic        InstrValid
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] req_addr, req_addr_nxt;
    ifid_entry_t     skid, skid_nxt;
    ifid_entry_t     ifid_entry;
    logic            ifid_load, ifid_hold, ifid_flush;
    logic [XLEN-1:0] req_addr_inc;
    logic [XLEN-1:0] redirect_target;

    assign req_addr_inc    = req_addr + PC_INC;
    assign redirect_target = word_align(RedirectPC);
    assign ImemAddr        = req_addr;

    // State, PC, request address and skid buffer registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= BOOT;
            pc       <= word_align(RESET_PC);
            req_addr <= word_align(RESET_PC);
            skid     <= '0;
            ImemReq  <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            req_addr <= req_addr_nxt;
            skid     <= skid_nxt;
            ImemReq  <= (state_nxt == FETCH) || (state_nxt == DRAIN);
        end
    end

    // Next-state, PC/skid update and IF/ID control
    always_comb begin
        state_nxt          = state;
        pc_nxt             = pc;
        req_addr_nxt       = req_addr;
        skid_nxt           = skid;
        ifid_load          = 1'b0;
        ifid_hold          = 1'b0;
        ifid_flush         = 1'b0;
        ifid_entry.instr   = ImemRdata;
        ifid_entry.pcplus4 = req_addr_inc;
        ifid_entry.valid   = 1'b1;

        if (RedirectValid) begin
            ifid_flush     = 1'b1;
            skid_nxt.valid = 1'b0;
            pc_nxt         = redirect_target;
            // An unacked request must be drained before the target can be issued
            if (((state == FETCH) || (state == DRAIN)) && !ImemAck) begin
                state_nxt = DRAIN;
            end else begin
                req_addr_nxt = redirect_target;
                state_nxt    = FETCH;
            end
        end else begin
            ifid_hold = Stall;
            unique case (state)
                BOOT: state_nxt = FETCH;
                FETCH: begin
                    if (ImemAck) begin
                        pc_nxt = req_addr_inc;
                        if (Stall) begin
                            skid_nxt.instr   = ImemRdata;
                            skid_nxt.pcplus4 = req_addr_inc;
                            skid_nxt.valid   = 1'b1;
                            state_nxt        = HOLD;
                        end else begin
                            ifid_load    = 1'b1;
                            req_addr_nxt = req_addr_inc;
                        end
                    end
                end
                HOLD: begin
                    if (!Stall) begin
                        ifid_load      = 1'b1;
                        ifid_entry     = skid;
                        skid_nxt.valid = 1'b0;
                        req_addr_nxt   = pc;
                        state_nxt      = FETCH;
                    end
                end
                DRAIN: begin
                    if (ImemAck) begin
                        req_addr_nxt = pc;
                        state_nxt    = FETCH;
                    end
                end
                default: state_nxt = BOOT;
            endcase
        end
    end

    if_id_register u_if_id (
        .Clk         (Clk),
        .Rst         (Rst),
        .load        (ifid_load),
        .hold        (ifid_hold),
        .flush       (ifid_flush),
        .entry_in    (ifid_entry),
        .Instruction (Instruction),
        .PCPlus4     (PCPlus4),
        .InstrValid  (InstrValid)
    );

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage with IF/ID pipeline register. Holds the PC and issues single-outstanding word requests to instruction memory over a request/acknowledge handshake. Presents the fetched word on `Instruction` to the decode-stage controller. Supports decode stalls through a one-entry skid buffer, and branch/jump redirects that flush the IF/ID register.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.

Ports:
- `Clk`, in, 1: clock, rising edge.
- `Rst`, in, 1: reset, asynchronous, active-high.
- `ImemReq`, out, 1: fetch request, registered.
- `ImemAddr`, out, 32: word address of the outstanding request. Bits [1:0] are always 0.
- `ImemAck`, in, 1: one-cycle pulse. `ImemRdata` is valid in the same cycle.
- `ImemRdata`, in, 32: fetched word.
- `Stall`, in, 1: decode cannot accept. Hold IF/ID.
- `RedirectValid`, in, 1: taken branch/jump; flush and refetch.
- `RedirectPC`, in, 32: redirect target. Bits [1:0] are ignored and forced to 00.
- `Instruction`, out, 32: IF/ID instruction to the controller.
- `PCPlus4`, out, 32: IF/ID PC+4 of `Instruction`.
- `InstrValid`, out, 1: IF/ID holds a real instruction. When 0, `Instruction` is the NOP 32'h0.

## Operation
- Registers:
  - `PC`: next fetch address.
  - `ReqAddr`: drives `ImemAddr`.
  - Skid buffer: word, PC+4, and a valid bit.
  - IF/ID: `Instruction`, `PCPlus4`, `InstrValid`.
  - State.
- States: BOOT, FETCH, HOLD, DRAIN.
- Reset values:
  - State = BOOT, `PC` = `RESET_PC`, `ReqAddr` = `RESET_PC`.
  - `ImemReq` = 0, `Instruction` = 0, `PCPlus4` = 0, `InstrValid` = 0.
  - Skid valid = 0.
- BOOT → FETCH unconditionally after one cycle. `ImemReq` = 1 in FETCH and DRAIN, 0 otherwise.
- FETCH, ack with `Stall` = 0:
  - IF/ID ← {`ImemRdata`, `ReqAddr`+4, 1}.
  - `PC` ← `ReqAddr`+4, `ReqAddr` ← `ReqAddr`+4.
  - Stay in FETCH.
- FETCH, no ack, `Stall` = 0: IF/ID ← bubble {0, 0, 0}.
- FETCH, ack with `Stall` = 1:
  - Skid ← {`ImemRdata`, `ReqAddr`+4, 1}.
  - `PC` ← `ReqAddr`+4.
  - Go to HOLD. IF/ID is unchanged.
- HOLD, `Stall` = 0:
  - IF/ID ← skid; skid valid ← 0.
  - `ReqAddr` ← `PC`.
  - Go to FETCH.
- `Stall` = 1 with no redirect: IF/ID holds in every state.
- Redirect has highest priority, in any state, regardless of `Stall`:
  - IF/ID ← bubble; skid valid ← 0.
  - `PC` ← {`RedirectPC`[31:2], 2'b00}.
  - If FETCH with no ack in the same cycle: go to DRAIN. `ReqAddr` holds, because the request is still outstanding.
  - Otherwise, including FETCH with an ack in the same cycle: `ReqAddr` ← new `PC`, go to FETCH. Any acked word is discarded.
- DRAIN:
  - Keep `ImemReq` high with the old address until the ack, then discard the data.
  - On the ack: `ReqAddr` ← `PC`, go to FETCH.
  - A second redirect in DRAIN overwrites `PC` and stays in DRAIN.
- Arithmetic: 32-bit PC+4 wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- An ack outside FETCH/DRAIN is a protocol error. It is ignored.

## Timing
- Zero-wait memory (ack in the same cycle as the request): one instruction per cycle. `Instruction` updates on the edge after the ack.
- Redirect cycle R:
  - Bubble visible at R+1.
  - First request to the target at R+1, or later if draining.
  - Earliest valid target instruction at R+2.
- Stall release: the skid word appears in IF/ID one cycle after `Stall` falls. Fetching resumes in the same cycle.
- `ImemAddr` is stable whenever `ImemReq` = 1 until the ack.
- `Rst` mid-request: the outstanding ack is abandoned. The memory side must tolerate this.

## Structure
- Shared package `fetch_pkg`:
  - State enum (BOOT, FETCH, HOLD, DRAIN).
  - `NOP_INSTR` = 32'h0000_0000.
  - `PC_INC` = 4.
- One sub-module: `if_id_register`. It holds `Instruction`, `PCPlus4` and `InstrValid`, with load, hold (stall) and flush inputs, plus async reset to the bubble.
- FSM, PC and skid buffer live in the top.

## Test plan
- Reset release, zero-wait memory returning addr-derived words:
  - `ImemAddr` sequence: 0, 4, 8, ….
  - `Instruction` follows with a 1-cycle lag.
  - `PCPlus4` = 4, 8, 12, ….
- `Stall` raised for 3 cycles while an ack arrives:
  - IF/ID frozen.
  - `ImemReq` = 0 during HOLD.
  - On release the word appears next cycle, then fetch resumes at the next address with no loss or duplication.
- `RedirectValid` with `RedirectPC` = 32'h0000_0103, zero-wait memory:
  - Bubble next cycle (`InstrValid` = 0, `Instruction` = 0).
  - `ImemAddr` = 32'h100.
  - Target word valid two cycles after the redirect.
- Redirect while a 3-cycle-latency request to 0x20 is outstanding:
  - `ImemAddr` stays 0x20 until the ack.
  - The returned word never reaches IF/ID.
  - Next request goes to the redirect target.
- Redirect in the same cycle as an ack with `Stall` = 1: skid cleared, IF/ID flushed, fetch restarts at the target.
- `RESET_PC` = 32'hFFFF_FFFC: second request address is 0. Assert `Rst` mid-DRAIN: all outputs return to reset values immediately.
